// File: rtl/cgr_kmer_addr_if.sv
// cgr_kmer_addr_if: symbol-in / address-out handshake bundle of the CGR
// k-mer address generator. The master modport is the generator side and the
// slave modport is the environment (symbol decoder plus CGR count RAM).
interface cgr_kmer_addr_if #(
  parameter int K_MAX = 8
) ();
  logic                 sym_valid;
  logic [1:0]           sym;
  logic                 sym_n;
  logic                 sym_ready;
  logic [2*K_MAX-1:0]   addr;
  logic                 addr_valid;
  logic                 addr_ready;
  logic                 clr_ram;

  modport master (
    input  sym_valid, sym, sym_n, addr_ready,
    output sym_ready, addr, addr_valid, clr_ram
  );

  modport slave (
    output sym_valid, sym, sym_n, addr_ready,
    input  sym_ready, addr, addr_valid, clr_ram
  );
endinterface

// File: rtl/cgr_kmer_addr.sv
// cgr_kmer_addr: converts a stream of 2-bit DNA symbols into chaos-game-
// representation k-mer addresses {x_field, y_field} for the CGR count RAM.
// A start first sweeps every RAM address with clr_ram=1, then the RUN phase
// emits one address per accepted symbol once the window holds k symbols.
// An ambiguous base (sym_n) restarts the window.
// Optional statistics (n_cnt_o, stall_cnt_o) are built when CGR_STATS_EN
// is defined. K_MAX must be at least 2.
module cgr_kmer_addr #(
  parameter int K_MAX   = 8,
  parameter int CTR_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  cgr_kmer_addr_if.master             bus,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [$clog2(K_MAX+1)-1:0]  cfg_k_i,
  output logic                        busy_o,
  output logic [CTR_LEN-1:0]          kmer_cnt_o
`ifdef CGR_STATS_EN
  ,
  output logic [CTR_LEN-1:0]          n_cnt_o,
  output logic [CTR_LEN-1:0]          stall_cnt_o
`endif
);

  localparam int            KW      = $clog2(K_MAX+1);
  localparam int            AW      = 2*K_MAX;
  localparam logic [KW-1:0] K_MAX_W = KW'(K_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Saturating +1 used by every event counter.
  function automatic logic [CTR_LEN-1:0] sat_inc(input logic [CTR_LEN-1:0] v);
    if (v == {CTR_LEN{1'b1}}) begin
      return v;
    end else begin
      return v + CTR_LEN'(1);
    end
  endfunction

  // Orders outside 1..K_MAX fall back to the maximum order.
  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if ((k == {KW{1'b0}}) || (k > K_MAX_W)) begin
      return K_MAX_W;
    end else begin
      return k;
    end
  endfunction

  // Right-justify the newest k bits of a shift register: newest lands on
  // bit k-1, the oldest in-window bit on bit 0, everything above is zero.
  function automatic logic [K_MAX-1:0] justify(input logic [K_MAX-1:0] s,
                                               input logic [KW-1:0]    k);
    return s >> (K_MAX_W - k);
  endfunction

  state_e               state_q, state_d;
  logic [KW-1:0]        k_lat_q, k_lat_d;
  logic [KW-1:0]        fill_q, fill_d;
  logic [K_MAX-1:0]     sx_q, sx_d;
  logic [K_MAX-1:0]     sy_q, sy_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 addr_valid_q, addr_valid_d;
  logic                 clr_ram_q, clr_ram_d;
  logic                 stop_q, stop_d;
  logic [CTR_LEN-1:0]   kmer_cnt_q, kmer_cnt_d;
`ifdef CGR_STATS_EN
  logic [CTR_LEN-1:0]   n_cnt_q, n_cnt_d;
  logic [CTR_LEN-1:0]   stall_cnt_q, stall_cnt_d;
`endif

  logic                 sym_ready_s;
  logic                 sym_acc_s;
  logic                 addr_hs_s;
  logic [K_MAX-1:0]     sx_shift_s;
  logic [K_MAX-1:0]     sy_shift_s;
  logic [KW-1:0]        fill_inc_s;

  // A stop already seen blocks further symbols so the pending address can drain.
  assign sym_ready_s = (state_q == ST_RUN) && !stop_q && (!addr_valid_q || bus.addr_ready);
  assign sym_acc_s   = bus.sym_valid && sym_ready_s;
  assign addr_hs_s   = addr_valid_q && bus.addr_ready;
  assign sx_shift_s  = {bus.sym[1], sx_q[K_MAX-1:1]};
  assign sy_shift_s  = {bus.sym[0], sy_q[K_MAX-1:1]};
  assign fill_inc_s  = (fill_q >= k_lat_q) ? k_lat_q : (fill_q + KW'(1));

  // Next-state and datapath update for the IDLE / CLEAR / RUN controller.
  always_comb begin
    state_d      = state_q;
    k_lat_d      = k_lat_q;
    fill_d       = fill_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    clr_ram_d    = clr_ram_q;
    stop_d       = stop_q;
    kmer_cnt_d   = kmer_cnt_q;
`ifdef CGR_STATS_EN
    n_cnt_d      = n_cnt_q;
    stall_cnt_d  = stall_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_CLEAR;
          k_lat_d      = clamp_k(cfg_k_i);
          fill_d       = {KW{1'b0}};
          sx_d         = {K_MAX{1'b0}};
          sy_d         = {K_MAX{1'b0}};
          kmer_cnt_d   = {CTR_LEN{1'b0}};
          addr_d       = {AW{1'b0}};
          addr_valid_d = 1'b1;
          clr_ram_d    = 1'b1;
          stop_d       = 1'b0;
`ifdef CGR_STATS_EN
          n_cnt_d      = {CTR_LEN{1'b0}};
          stall_cnt_d  = {CTR_LEN{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        // The address register doubles as the sweep counter.
        if (addr_hs_s) begin
          if (addr_q == {AW{1'b1}}) begin
            state_d      = ST_RUN;
            addr_d       = {AW{1'b0}};
            addr_valid_d = 1'b0;
            clr_ram_d    = 1'b0;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end

      ST_RUN: begin
        if (addr_hs_s) begin
          addr_valid_d = 1'b0;
        end else begin
          addr_valid_d = addr_valid_q;
        end

        if (sym_acc_s) begin
          if (bus.sym_n) begin
            fill_d = {KW{1'b0}};
            sx_d   = {K_MAX{1'b0}};
            sy_d   = {K_MAX{1'b0}};
`ifdef CGR_STATS_EN
            n_cnt_d = sat_inc(n_cnt_q);
`endif
          end else begin
            sx_d   = sx_shift_s;
            sy_d   = sy_shift_s;
            fill_d = fill_inc_s;
            if (fill_inc_s == k_lat_q) begin
              addr_d       = {justify(sx_shift_s, k_lat_q), justify(sy_shift_s, k_lat_q)};
              addr_valid_d = 1'b1;
              kmer_cnt_d   = sat_inc(kmer_cnt_q);
            end else begin
              addr_d = addr_q;
            end
          end
        end else begin
          fill_d = fill_q;
        end

`ifdef CGR_STATS_EN
        if (bus.sym_valid && !sym_ready_s) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
`endif

        if (stop_q) begin
          if (!addr_valid_q || bus.addr_ready) begin
            state_d      = ST_IDLE;
            addr_valid_d = 1'b0;
            stop_d       = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else if (stop_i) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        addr_valid_d = 1'b0;
        clr_ram_d    = 1'b0;
        stop_d       = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_lat_q      <= K_MAX_W;
      fill_q       <= {KW{1'b0}};
      sx_q         <= {K_MAX{1'b0}};
      sy_q         <= {K_MAX{1'b0}};
      addr_q       <= {AW{1'b0}};
      addr_valid_q <= 1'b0;
      clr_ram_q    <= 1'b0;
      stop_q       <= 1'b0;
      kmer_cnt_q   <= {CTR_LEN{1'b0}};
`ifdef CGR_STATS_EN
      n_cnt_q      <= {CTR_LEN{1'b0}};
      stall_cnt_q  <= {CTR_LEN{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      k_lat_q      <= k_lat_d;
      fill_q       <= fill_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      clr_ram_q    <= clr_ram_d;
      stop_q       <= stop_d;
      kmer_cnt_q   <= kmer_cnt_d;
`ifdef CGR_STATS_EN
      n_cnt_q      <= n_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign bus.sym_ready  = sym_ready_s;
  assign bus.addr       = addr_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.clr_ram    = clr_ram_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign kmer_cnt_o     = kmer_cnt_q;
`ifdef CGR_STATS_EN
  assign n_cnt_o        = n_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cgr_kmer_addr.sv
// tb_cgr_kmer_addr: self-checking bench. A K_MAX=8 instance covers the full
// 64K clear sweep, reset during CLEAR and order clamping; a K_MAX=4 instance
// with a 4-bit counter covers the windowing rules, backpressure, stop and a
// randomized run against a symbol-history reference model.
module tb_cgr_kmer_addr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Big instance: K_MAX=8, CTR_LEN=16.
  cgr_kmer_addr_if #(.K_MAX(8)) bb ();
  logic        start_b = 1'b0;
  logic        stop_b  = 1'b0;
  logic [3:0]  cfg_b   = 4'd0;
  logic        busy_b;
  logic [15:0] kmer_b;
`ifdef CGR_STATS_EN
  logic [15:0] ncnt_b, stall_b;
`endif

  cgr_kmer_addr #(.K_MAX(8), .CTR_LEN(16)) u_big (
    .clk(clk), .rst(rst), .bus(bb.master),
    .start_i(start_b), .stop_i(stop_b), .cfg_k_i(cfg_b),
    .busy_o(busy_b), .kmer_cnt_o(kmer_b)
`ifdef CGR_STATS_EN
    , .n_cnt_o(ncnt_b), .stall_cnt_o(stall_b)
`endif
  );

  // Small instance: K_MAX=4, CTR_LEN=4 so counter saturation is reachable.
  cgr_kmer_addr_if #(.K_MAX(4)) ss ();
  logic        start_s = 1'b0;
  logic        stop_s  = 1'b0;
  logic [2:0]  cfg_s   = 3'd0;
  logic        busy_s;
  logic [3:0]  kmer_s;
`ifdef CGR_STATS_EN
  logic [3:0]  ncnt_s, stall_s;
`endif

  cgr_kmer_addr #(.K_MAX(4), .CTR_LEN(4)) u_small (
    .clk(clk), .rst(rst), .bus(ss.master),
    .start_i(start_s), .stop_i(stop_s), .cfg_k_i(cfg_s),
    .busy_o(busy_s), .kmer_cnt_o(kmer_s)
`ifdef CGR_STATS_EN
    , .n_cnt_o(ncnt_s), .stall_cnt_o(stall_s)
`endif
  );

  // Reference model for the small instance: history of the current window.
  int         mk;
  logic [1:0] hist[$];
  bit         m_valid;
  logic [7:0] m_addr;
  int         m_cnt, m_n, m_stall;

  function automatic logic [7:0] win_addr();
    int x = 0;
    int y = 0;
    int sz = hist.size();
    for (int j = 0; j < mk; j++) begin
      logic [1:0] s;
      s = hist[sz-1-j];
      if (s[1]) x += (1 << (mk-1-j));
      if (s[0]) y += (1 << (mk-1-j));
    end
    return {4'(x), 4'(y)};
  endfunction

  task automatic model_advance(input bit sv, input logic [1:0] sy, input bit sn, input bit ar);
    bit rdy;
    rdy = !m_valid || ar;
    if (m_valid && ar) m_valid = 1'b0;
    if (sv && rdy) begin
      if (sn) begin
        hist.delete();
        if (m_n < 15) m_n++;
      end else begin
        hist.push_back(sy);
        if (hist.size() > mk) void'(hist.pop_front());
        if (hist.size() == mk) begin
          m_valid = 1'b1;
          m_addr  = win_addr();
          if (m_cnt < 15) m_cnt++;
        end
      end
    end else if (sv) begin
      if (m_stall < 15) m_stall++;
    end
  endtask

  task automatic start_small(input int cfg);
    int n, bad, g;
    n = 0; bad = 0; g = 0;
    @(posedge clk); #1;
    start_s = 1'b1; cfg_s = 3'(cfg); stop_s = 1'b0;
    ss.sym_valid = 1'b0; ss.sym_n = 1'b0; ss.addr_ready = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    @(negedge clk);
    while (ss.addr_valid && ss.clr_ram && g < 600) begin
      if (ss.addr !== 8'(n)) bad++;
      n++; g++;
      @(posedge clk); #1;
      start_s = (n == 100);
      stop_s  = (n == 150);
      @(negedge clk);
    end
    start_s = 1'b0; stop_s = 1'b0;
    checks++;
    if (n != 256 || bad != 0) begin
      failures++; $display("FAIL clear_sweep_small: got %0d addrs (%0d out of order), want 256 (0 out of order)", n, bad);
    end
    checks++;
    if ({ss.addr_valid, ss.clr_ram, busy_s, kmer_s} !== 7'b0010000) begin
      failures++; $display("FAIL run_entry_small: got v=%b clr=%b busy=%b kmer=%0d, want 0 0 1 0", ss.addr_valid, ss.clr_ram, busy_s, kmer_s);
    end
    mk = (cfg == 0 || cfg > 4) ? 4 : cfg;
    hist.delete();
    m_valid = 1'b0; m_cnt = 0; m_n = 0; m_stall = 0;
  endtask

  task automatic stop_small;
    int g;
    g = 0;
    @(posedge clk); #1;
    stop_s = 1'b1; ss.sym_valid = 1'b0; ss.addr_ready = 1'b1;
    @(posedge clk); #1;
    stop_s = 1'b0;
    while (busy_s && g < 20) begin
      @(posedge clk); #1; g++;
    end
    checks++;
    if (busy_s !== 1'b0) begin
      failures++; $display("FAIL stop_to_idle: got busy=%b, want 0", busy_s);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bb.sym_valid = 1'b0; bb.sym = 2'd0; bb.sym_n = 1'b0; bb.addr_ready = 1'b0;
    ss.sym_valid = 1'b0; ss.sym = 2'd0; ss.sym_n = 1'b0; ss.addr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bb.addr, bb.addr_valid, bb.clr_ram, bb.sym_ready} !== 19'd0) begin
      failures++; $display("FAIL reset_big_bus: got addr=%h v=%b clr=%b rdy=%b, want all 0", bb.addr, bb.addr_valid, bb.clr_ram, bb.sym_ready);
    end
    checks++;
    if ({busy_b, kmer_b} !== 17'd0) begin
      failures++; $display("FAIL reset_big_status: got busy=%b kmer=%0d, want 0 0", busy_b, kmer_b);
    end
    checks++;
    if ({ss.addr, ss.addr_valid, ss.clr_ram, ss.sym_ready, busy_s, kmer_s} !== 16'd0) begin
      failures++; $display("FAIL reset_small: got addr=%h v=%b clr=%b rdy=%b busy=%b kmer=%0d, want all 0", ss.addr, ss.addr_valid, ss.clr_ram, ss.sym_ready, busy_s, kmer_s);
    end
  endtask

  task automatic test_reset_mid_clear;
    int g;
    g = 0;
    @(posedge clk); #1;
    start_b = 1'b1; cfg_b = 4'd8; bb.addr_ready = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    while (bb.addr !== 16'h1234 && g < 6000) begin
      @(negedge clk); g++;
    end
    checks++;
    if (bb.addr !== 16'h1234 || bb.clr_ram !== 1'b1) begin
      failures++; $display("FAIL reach_1234: got addr=%h clr=%b, want 1234 1", bb.addr, bb.clr_ram);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bb.addr, bb.addr_valid, bb.clr_ram, bb.sym_ready, busy_b, kmer_b} !== 36'd0) begin
      failures++; $display("FAIL async_reset: got addr=%h v=%b clr=%b busy=%b, want all 0", bb.addr, bb.addr_valid, bb.clr_ram, busy_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_sweep;
    int n, bad, first_bad, g;
    n = 0; bad = 0; first_bad = -1; g = 0;
    @(posedge clk); #1;
    start_b = 1'b1; cfg_b = 4'd0; bb.addr_ready = 1'b1; bb.sym_valid = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b0;
    @(negedge clk);
    while (bb.addr_valid && bb.clr_ram && g < 70000) begin
      if (bb.addr !== 16'(n)) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
      n++; g++;
      @(negedge clk);
    end
    checks++;
    if (n != 65536 || bad != 0) begin
      failures++; $display("FAIL clear_sweep_big: got %0d addrs, %0d wrong (first at %0d), want 65536 0", n, bad, first_bad);
    end
    checks++;
    if ({bb.addr_valid, bb.clr_ram, busy_b} !== 3'b001) begin
      failures++; $display("FAIL run_entry_big: got v=%b clr=%b busy=%b, want 0 0 1", bb.addr_valid, bb.clr_ram, busy_b);
    end
  endtask

  task automatic test_kclamp;
    logic [1:0] s[8];
    logic [7:0] xb, yb;
    int emits;
    emits = 0;
    for (int i = 0; i < 8; i++) begin
      s[i]  = 2'($urandom_range(0, 3));
      xb[i] = s[i][1];
      yb[i] = s[i][0];
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bb.sym_valid = 1'b1; bb.sym = s[i]; bb.sym_n = 1'b0; bb.addr_ready = 1'b1;
      @(negedge clk);
      if (bb.addr_valid) emits++;
    end
    checks++;
    if (emits != 0) begin
      failures++; $display("FAIL kclamp_early: got %0d addrs before 8th symbol, want 0", emits);
    end
    @(posedge clk); #1;
    bb.sym_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bb.addr_valid !== 1'b1 || bb.addr !== {xb, yb} || kmer_b !== 16'd1) begin
      failures++; $display("FAIL kclamp_addr: got v=%b addr=%h kmer=%0d, want 1 %h 1", bb.addr_valid, bb.addr, kmer_b, {xb, yb});
    end
  endtask

  task automatic test_k2;
    logic [1:0] seq[3];
    logic       vs[5];
    seq[0] = 2'b11; seq[1] = 2'b01; seq[2] = 2'b00;
    start_small(2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ss.sym_valid = (c < 3); ss.sym = (c < 3) ? seq[c] : 2'b00; ss.sym_n = 1'b0; ss.addr_ready = 1'b1;
      @(negedge clk);
      vs[c] = ss.addr_valid;
      if (c == 2) begin
        checks++;
        if (ss.addr_valid !== 1'b1 || ss.addr !== 8'h13) begin
          failures++; $display("FAIL k2_first: got v=%b addr=%h, want 1 13", ss.addr_valid, ss.addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (ss.addr_valid !== 1'b1 || ss.addr !== 8'h01 || kmer_s !== 4'd2) begin
          failures++; $display("FAIL k2_second: got v=%b addr=%h kmer=%0d, want 1 01 2", ss.addr_valid, ss.addr, kmer_s);
        end
      end
    end
    checks++;
    if ({vs[0], vs[1], vs[4]} !== 3'b000) begin
      failures++; $display("FAIL k2_quiet: got valid at c0,c1,c4 = %b%b%b, want 000", vs[0], vs[1], vs[4]);
    end
    stop_small();
  endtask

  task automatic test_k3_n;
    logic [1:0] seq[6];
    bit         nflag[6];
    int         emits;
    seq = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01};
    nflag = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    emits = 0;
    start_small(3);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      ss.sym_valid = 1'b1; ss.sym = seq[c]; ss.sym_n = nflag[c]; ss.addr_ready = 1'b1;
      @(negedge clk);
      if (ss.addr_valid) emits++;
    end
    checks++;
    if (emits != 0) begin
      failures++; $display("FAIL k3n_early: got %0d addrs before 6th symbol, want 0", emits);
    end
    @(posedge clk); #1;
    ss.sym_valid = 1'b0; ss.sym_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ss.addr_valid !== 1'b1 || ss.addr !== 8'h07 || kmer_s !== 4'd1) begin
      failures++; $display("FAIL k3n_addr: got v=%b addr=%h kmer=%0d, want 1 07 1", ss.addr_valid, ss.addr, kmer_s);
    end
`ifdef CGR_STATS_EN
    checks++;
    if (ncnt_s !== 4'd1) begin
      failures++; $display("FAIL k3n_ncnt: got %0d, want 1", ncnt_s);
    end
`endif
    stop_small();
  endtask

  task automatic test_stall;
    logic [1:0] sq[7];
    bit         ar[7];
    bit         sv[7];
    sq = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00};
    ar = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start_small(1);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      ss.sym_valid = sv[c]; ss.sym = sq[c]; ss.sym_n = 1'b0; ss.addr_ready = ar[c];
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (ss.sym_ready !== 1'b1) begin
          failures++; $display("FAIL stall_c0_ready: got %b, want 1", ss.sym_ready);
        end
      end else if (c <= 3) begin
        checks++;
        if (ss.sym_ready !== 1'b0 || ss.addr_valid !== 1'b1 || ss.addr !== 8'h10) begin
          failures++; $display("FAIL stall_hold c%0d: got rdy=%b v=%b addr=%h, want 0 1 10", c, ss.sym_ready, ss.addr_valid, ss.addr);
        end
      end else if (c == 4) begin
        checks++;
        if (ss.sym_ready !== 1'b1 || ss.addr_valid !== 1'b1 || ss.addr !== 8'h10) begin
          failures++; $display("FAIL stall_release: got rdy=%b v=%b addr=%h, want 1 1 10", ss.sym_ready, ss.addr_valid, ss.addr);
        end
      end else if (c == 5) begin
        checks++;
        if (ss.addr_valid !== 1'b1 || ss.addr !== 8'h01) begin
          failures++; $display("FAIL stall_b2b1: got v=%b addr=%h, want 1 01", ss.addr_valid, ss.addr);
        end
      end else begin
        checks++;
        if (ss.addr_valid !== 1'b1 || ss.addr !== 8'h11 || kmer_s !== 4'd3) begin
          failures++; $display("FAIL stall_b2b2: got v=%b addr=%h kmer=%0d, want 1 11 3", ss.addr_valid, ss.addr, kmer_s);
        end
`ifdef CGR_STATS_EN
        checks++;
        if (stall_s !== 4'd3) begin
          failures++; $display("FAIL stall_cnt: got %0d, want 3", stall_s);
        end
`endif
      end
    end
    stop_small();
  endtask

  task automatic test_stop;
    start_small(1);
    @(posedge clk); #1;
    ss.sym_valid = 1'b1; ss.sym = 2'b11; ss.sym_n = 1'b0; ss.addr_ready = 1'b0; stop_s = 1'b1;
    @(negedge clk);
    checks++;
    if (ss.sym_ready !== 1'b1) begin
      failures++; $display("FAIL stop_same_cycle: got rdy=%b, want 1", ss.sym_ready);
    end
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      stop_s = 1'b0; ss.sym = 2'b01; ss.addr_ready = (c == 3);
      @(negedge clk);
      checks++;
      if (ss.sym_ready !== 1'b0 || ss.addr_valid !== 1'b1 || ss.addr !== 8'h11 || busy_s !== 1'b1) begin
        failures++; $display("FAIL stop_drain c%0d: got rdy=%b v=%b addr=%h busy=%b, want 0 1 11 1", c, ss.sym_ready, ss.addr_valid, ss.addr, busy_s);
      end
    end
    @(posedge clk); #1;
    ss.sym_valid = 1'b0; ss.addr_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || ss.addr_valid !== 1'b0 || ss.sym_ready !== 1'b0 || kmer_s !== 4'd1) begin
      failures++; $display("FAIL stop_idle: got busy=%b v=%b rdy=%b kmer=%0d, want 0 0 0 1", busy_s, ss.addr_valid, ss.sym_ready, kmer_s);
    end
  endtask

  task automatic test_random;
    bit         sv, sn, ar, exp_rdy;
    logic [1:0] sy;
    for (int r = 0; r < 3; r++) begin
      start_small($urandom_range(0, 7));
      for (int c = 0; c < 300; c++) begin
        sv = ($urandom_range(0, 3) != 0);
        sy = 2'($urandom_range(0, 3));
        sn = ($urandom_range(0, 9) == 0);
        ar = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
        ss.sym_valid = sv; ss.sym = sy; ss.sym_n = sn; ss.addr_ready = ar;
        @(negedge clk);
        exp_rdy = !m_valid || ar;
        checks++;
        if (ss.sym_ready !== exp_rdy) begin
          failures++; $display("FAIL rnd_ready r%0d c%0d: got %b, want %b", r, c, ss.sym_ready, exp_rdy);
        end
        checks++;
        if (ss.addr_valid !== m_valid) begin
          failures++; $display("FAIL rnd_valid r%0d c%0d: got %b, want %b", r, c, ss.addr_valid, m_valid);
        end
        if (m_valid) begin
          checks++;
          if (ss.addr !== m_addr) begin
            failures++; $display("FAIL rnd_addr r%0d c%0d k=%0d: got %h, want %h", r, c, mk, ss.addr, m_addr);
          end
        end
        checks++;
        if (kmer_s !== 4'(m_cnt)) begin
          failures++; $display("FAIL rnd_kmer r%0d c%0d: got %0d, want %0d", r, c, kmer_s, m_cnt);
        end
        model_advance(sv, sy, sn, ar);
      end
      @(posedge clk); #1;
      ss.sym_valid = 1'b0; ss.sym_n = 1'b0;
      @(negedge clk);
`ifdef CGR_STATS_EN
      checks++;
      if (ncnt_s !== 4'(m_n) || stall_s !== 4'(m_stall)) begin
        failures++; $display("FAIL rnd_stats r%0d: got n=%0d stall=%0d, want %0d %0d", r, ncnt_s, stall_s, m_n, m_stall);
      end
`endif
      stop_small();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_full_sweep();
    test_kclamp();
    test_k2();
    test_k3_n();
    test_stall();
    test_stop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
